// File: rtl/dwc_downconv_wr_seq_if.sv
// dwc_downconv_wr_seq_if: command, slave AW/W and master W signals of the down-converter write sequencer
interface dwc_downconv_wr_seq_if #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 32
);
  logic                  hold_reg_empty;
  logic                  hold_get_next_data;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [ID_WIDTH-1:0]   cmd_id;
  logic [2:0]            cmd_size;
  logic [7:0]            slaveLen_M1;
  logic                  SLAVE_AWVALID;
  logic                  SLAVE_AWREADY;
  logic [ADDR_WIDTH-1:0] SLAVE_AWADDR;
  logic [7:0]            SLAVE_AWLEN;
  logic [2:0]            SLAVE_AWSIZE;
  logic [ID_WIDTH-1:0]   SLAVE_AWID;
  logic                  MASTER_WVALID;
  logic                  MASTER_WREADY;
  logic                  SLAVE_WVALID;
  logic                  SLAVE_WREADY;
  logic                  SLAVE_WLAST;
  logic [5:0]            lane_offset;

  modport master (
    input  hold_reg_empty, cmd_addr, cmd_id, cmd_size, slaveLen_M1,
           SLAVE_AWREADY, MASTER_WVALID, SLAVE_WREADY,
    output hold_get_next_data, SLAVE_AWVALID, SLAVE_AWADDR, SLAVE_AWLEN,
           SLAVE_AWSIZE, SLAVE_AWID, MASTER_WREADY, SLAVE_WVALID,
           SLAVE_WLAST, lane_offset
  );

  modport slave (
    output hold_reg_empty, cmd_addr, cmd_id, cmd_size, slaveLen_M1,
           SLAVE_AWREADY, MASTER_WVALID, SLAVE_WREADY,
    input  hold_get_next_data, SLAVE_AWVALID, SLAVE_AWADDR, SLAVE_AWLEN,
           SLAVE_AWSIZE, SLAVE_AWID, MASTER_WREADY, SLAVE_WVALID,
           SLAVE_WLAST, lane_offset
  );
endinterface

// File: rtl/dwc_downconv_wr_seq.sv
// dwc_downconv_wr_seq: issues slave AW per command and slices each wide master W beat into narrow slave beats
module dwc_downconv_wr_seq #(
  parameter int ID_WIDTH     = 1,
  parameter int ADDR_WIDTH   = 32,
  parameter int MASTER_BYTES = 8
) (
  input logic                   ACLK,
  input logic                   sysReset,
  dwc_downconv_wr_seq_if.master bus
);
  typedef enum logic [1:0] {IDLE, AW, DATA} state_t;
  state_t                state;
  logic                  aw_valid;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]            aw_len;
  logic [2:0]            aw_size;
  logic [ID_WIDTH-1:0]   aw_id;
  logic [5:0]            lane;
  logic [7:0]            beat;
  logic [6:0]            step;
  logic [6:0]            sum;
  logic [5:0]            cmd_step;
  logic [5:0]            start_off;
  logic                  in_data;
  logic                  wlast;
  logic                  w_hs;
  logic                  load;

  assign in_data   = state == DATA;
  assign step      = 7'(1) << aw_size;
  assign sum       = {1'b0, lane} + step;
  assign wlast     = in_data & (beat == aw_len);
  assign w_hs      = in_data & bus.MASTER_WVALID & bus.SLAVE_WREADY;
  // a 64-byte step wraps cmd_step to 0, which correctly yields a zero start offset
  assign cmd_step  = 6'(1) << bus.cmd_size;
  assign start_off = bus.cmd_addr[5:0] & 6'(MASTER_BYTES - 1) & ~(cmd_step - 6'd1);
  // a command is taken from IDLE, or directly on the closing WLAST so back-to-back bursts skip IDLE
  assign load      = !sysReset & !bus.hold_reg_empty & ((state == IDLE) | (w_hs & wlast));

  assign bus.hold_get_next_data = load;
  assign bus.SLAVE_AWVALID      = aw_valid;
  assign bus.SLAVE_AWADDR       = aw_addr;
  assign bus.SLAVE_AWLEN        = aw_len;
  assign bus.SLAVE_AWSIZE       = aw_size;
  assign bus.SLAVE_AWID         = aw_id;
  assign bus.lane_offset        = lane;
  assign bus.SLAVE_WVALID       = in_data & bus.MASTER_WVALID;
  assign bus.SLAVE_WLAST        = wlast;
  assign bus.MASTER_WREADY      = in_data & bus.SLAVE_WREADY & (wlast | (sum >= 7'(MASTER_BYTES)));

  // command load, AW handshake and per-beat slice stepping
  always_ff @(posedge ACLK or posedge sysReset) begin
    if (sysReset) begin
      state    <= IDLE;
      aw_valid <= 1'b0;
      aw_addr  <= '0;
      aw_len   <= '0;
      aw_size  <= '0;
      aw_id    <= '0;
      lane     <= '0;
      beat     <= '0;
    end else if (load) begin
      state    <= AW;
      aw_valid <= 1'b1;
      aw_addr  <= bus.cmd_addr;
      aw_len   <= bus.slaveLen_M1;
      aw_size  <= bus.cmd_size;
      aw_id    <= bus.cmd_id;
      lane     <= start_off;
      beat     <= '0;
    end else if (state == AW && bus.SLAVE_AWREADY) begin
      state    <= DATA;
      aw_valid <= 1'b0;
    end else if (w_hs) begin
      beat  <= beat + 8'd1;
      lane  <= 6'(sum & 7'(MASTER_BYTES - 1));
      state <= wlast ? IDLE : DATA;
    end
  end
endmodule

// File: tb/tb_dwc_downconv_wr_seq.sv
// tb_dwc_downconv_wr_seq: table of commands with a per-beat scoreboard for the write sequencer
module tb_dwc_downconv_wr_seq;
  localparam int MB = 8;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  id;
    logic [2:0]  size;
    logic [7:0]  len;
    int          stall;
    bit          rnd;
    bit          b2b;
    logic [5:0]  lane0;
    int          mready;
  } vec_t;

  typedef struct {
    logic [5:0] lane;
    logic       last;
    logic       mr;
  } beat_t;

  logic  clk = 0;
  logic  rst = 1;
  bit    rnd = 0;
  int    n_checks = 0;
  int    n_fail = 0;
  int    mr_cnt = 0;
  beat_t q[$];
  vec_t  tab[8];

  dwc_downconv_wr_seq_if #(.ID_WIDTH(2), .ADDR_WIDTH(32)) bus();

  dwc_downconv_wr_seq #(.ID_WIDTH(2), .ADDR_WIDTH(32), .MASTER_BYTES(MB)) dut (
    .ACLK(clk),
    .sysReset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // W-side traffic: either continuous or random valid/ready gaps
  initial begin
    bus.MASTER_WVALID = 0;
    bus.SLAVE_WREADY  = 0;
    forever begin
      @(posedge clk);
      #1;
      bus.MASTER_WVALID = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.SLAVE_WREADY  = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // scoreboard: every slave W handshake consumes one expected beat
  always @(negedge clk) begin
    beat_t b;
    chk("get_while_empty", 64'(bus.hold_get_next_data & bus.hold_reg_empty), 64'd0);
    if (bus.SLAVE_WVALID && bus.SLAVE_WREADY) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL w_extra_beat: got beat lane %0d expected none", bus.lane_offset);
      end else begin
        b = q.pop_front();
        chk("w_lane", 64'(bus.lane_offset), 64'(b.lane));
        chk("w_last", 64'(bus.SLAVE_WLAST), 64'(b.last));
        chk("w_mready", 64'(bus.MASTER_WREADY), 64'(b.mr));
        if (bus.MASTER_WREADY) mr_cnt++;
      end
    end
  end

  task automatic issue(input vec_t e);
    int  step = 1 << e.size;
    int  base = int'(e.addr & 32'(MB - 1)) & ~(step - 1);
    bit  got = 0;
    for (int i = 0; i <= int'(e.len); i++) begin
      beat_t b;
      b.lane = 6'((base + i * step) % MB);
      b.last = (i == int'(e.len));
      b.mr   = b.last || (((base + i * step) % MB) + step >= MB);
      q.push_back(b);
    end
    @(posedge clk);
    #1;
    rnd = e.rnd;
    bus.hold_reg_empty = 0;
    bus.cmd_addr       = e.addr;
    bus.cmd_id         = e.id;
    bus.cmd_size       = e.size;
    bus.slaveLen_M1    = e.len;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = bus.hold_get_next_data;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL get_timeout: got no hold_get_next_data expected a pulse");
      bus.hold_reg_empty = 1;
      return;
    end
    if (e.b2b) chk("b2b_get_in_wlast", 64'(bus.SLAVE_WLAST), 64'd1);
    for (int i = 0; i <= e.stall; i++) begin
      @(posedge clk);
      #1;
      bus.hold_reg_empty = 1;
      bus.SLAVE_AWREADY  = (i == e.stall);
      @(negedge clk);
      chk("awvalid", 64'(bus.SLAVE_AWVALID), 64'd1);
      chk("awaddr", 64'(bus.SLAVE_AWADDR), 64'(e.addr));
      chk("awlen", 64'(bus.SLAVE_AWLEN), 64'(e.len));
      chk("awsize", 64'(bus.SLAVE_AWSIZE), 64'(e.size));
      chk("awid", 64'(bus.SLAVE_AWID), 64'(e.id));
      chk("lane_start", 64'(bus.lane_offset), 64'(e.lane0));
    end
    @(posedge clk);
    #1;
    bus.SLAVE_AWREADY = 0;
    @(negedge clk);
    chk("awvalid_drop", 64'(bus.SLAVE_AWVALID), 64'd0);
  endtask

  task automatic drain(input int exp_mr);
    for (int i = 0; i < 500 && q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("beats_outstanding", 64'(q.size()), 64'd0);
    chk("mready_count", 64'(mr_cnt), 64'(exp_mr));
    chk("idle_wvalid", 64'(bus.SLAVE_WVALID), 64'd0);
    chk("idle_get", 64'(bus.hold_get_next_data), 64'd0);
    mr_cnt = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_awvalid"}, 64'(bus.SLAVE_AWVALID), 64'd0);
    chk({tag, "_awaddr"}, 64'(bus.SLAVE_AWADDR), 64'd0);
    chk({tag, "_awlen"}, 64'(bus.SLAVE_AWLEN), 64'd0);
    chk({tag, "_wvalid"}, 64'(bus.SLAVE_WVALID), 64'd0);
    chk({tag, "_wlast"}, 64'(bus.SLAVE_WLAST), 64'd0);
    chk({tag, "_mready"}, 64'(bus.MASTER_WREADY), 64'd0);
    chk({tag, "_lane"}, 64'(bus.lane_offset), 64'd0);
    chk({tag, "_get"}, 64'(bus.hold_get_next_data), 64'd0);
  endtask

  initial begin
    int   acc = 0;
    vec_t r;
    tab[0] = '{32'h100, 2'd1, 3'd2, 8'd3,  3, 1'b0, 1'b0, 6'd0, 2};
    tab[1] = '{32'h104, 2'd2, 3'd2, 8'd2,  0, 1'b0, 1'b0, 6'd4, 2};
    tab[2] = '{32'h000, 2'd3, 3'd0, 8'd15, 1, 1'b1, 1'b0, 6'd0, 2};
    tab[3] = '{32'h000, 2'd0, 3'd3, 8'd0,  0, 1'b0, 1'b0, 6'd0, 1};
    tab[4] = '{32'h203, 2'd1, 3'd1, 8'd4,  1, 1'b0, 1'b0, 6'd2, 2};
    tab[5] = '{32'h038, 2'd2, 3'd3, 8'd2,  0, 1'b0, 1'b1, 6'd0, 3};
    tab[6] = '{32'h01C, 2'd3, 3'd2, 8'd1,  2, 1'b0, 1'b1, 6'd4, 2};
    tab[7] = '{32'h005, 2'd0, 3'd0, 8'd3,  0, 1'b1, 1'b0, 6'd5, 2};
    bus.hold_reg_empty = 1;
    bus.cmd_addr       = 0;
    bus.cmd_id         = 0;
    bus.cmd_size       = 0;
    bus.slaveLen_M1    = 0;
    bus.SLAVE_AWREADY  = 0;
    repeat (2) @(negedge clk);
    bus.hold_reg_empty = 0;
    bus.cmd_addr       = 32'h44;
    #1;
    check_all_zero("reset");
    bus.hold_reg_empty = 1;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    check_all_zero("post_reset");
    for (int k = 0; k < 8; k++) begin
      issue(tab[k]);
      acc += tab[k].mready;
      if (k == 7 || !tab[k + 1].b2b) begin
        drain(acc);
        acc = 0;
      end
    end
    r = '{32'h000, 2'd1, 3'd0, 8'd7, 0, 1'b0, 1'b0, 6'd0, 0};
    issue(r);
    for (int i = 0; i < 100 && q.size() > 5; i++) @(negedge clk);
    #2;
    rst = 1;
    #1;
    check_all_zero("mid_burst_reset");
    repeat (2) @(posedge clk);
    q.delete();
    mr_cnt = 0;
    #1;
    rst = 0;
    @(negedge clk);
    check_all_zero("after_abort");
    r = '{32'h10C, 2'd2, 3'd2, 8'd1, 1, 1'b0, 1'b0, 6'd4, 2};
    issue(r);
    drain(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
